// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester
// and the data (load/store) requester. Address phases are arbitrated with
// data priority, except that a fetch that has watched STARVE_MAX consecutive
// data grants go by gets the next grant. Every accepted address phase pushes
// its source ID into a small in-order FIFO. Responses coming back on the
// memory port are routed to the requester at the FIFO head.
//
// Parameters
//   OUTSTANDING  max in-flight transactions on the m_* port (power of two, >=1)
//   STARVE_MAX   data grants tolerated while a fetch waits (>=1)
//
// Ports
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_inst_* / o_inst_*                 fetch requester handshake
//   i_data_* / o_data_*                 load/store requester handshake
//   o_m_req/wr/size/addr/wdata          muxed request to the memory port
//   i_m_addr_ok, i_m_data_ok, i_m_rdata memory port handshake and read data
//   o_pending                           in-flight transaction count
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,

    input  logic                         i_inst_req,
    input  logic                         i_inst_wr,
    input  logic [1:0]                   i_inst_size,
    input  logic [31:0]                  i_inst_addr,
    input  logic [31:0]                  i_inst_wdata,
    output logic                         o_inst_addr_ok,
    output logic                         o_inst_data_ok,
    output logic [31:0]                  o_inst_rdata,

    input  logic                         i_data_req,
    input  logic                         i_data_wr,
    input  logic [1:0]                   i_data_size,
    input  logic [31:0]                  i_data_addr,
    input  logic [31:0]                  i_data_wdata,
    output logic                         o_data_addr_ok,
    output logic                         o_data_data_ok,
    output logic [31:0]                  o_data_rdata,

    output logic                         o_m_req,
    output logic                         o_m_wr,
    output logic [1:0]                   o_m_size,
    output logic [31:0]                  o_m_addr,
    output logic [31:0]                  o_m_wdata,
    input  logic                         i_m_addr_ok,
    input  logic                         i_m_data_ok,
    input  logic [31:0]                  i_m_rdata,

    output logic [$clog2(OUTSTANDING):0] o_pending
);

    localparam int PW   = $clog2(OUTSTANDING) + 1;
    localparam int PTRW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    logic [PW-1:0]          r_pending;
    logic [PTRW-1:0]        r_head;
    logic [PTRW-1:0]        r_tail;
    logic [OUTSTANDING-1:0] r_idFifo;
    logic [SW-1:0]          r_starveCnt;

    logic w_full;
    logic w_empty;
    logic w_instPrio;
    logic w_grantInst;
    logic w_grantData;
    logic w_push;
    logic w_pop;
    logic w_headId;

    // Pointers advance modulo OUTSTANDING; written as an explicit wrap so the
    // FIFO stays correct even if OUTSTANDING is ever not a power of two.
    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        if (p == PTRW'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Grant decision. A full FIFO blocks everything; a saturated starvation
    // counter lets a waiting fetch jump ahead of data. Only registered state
    // and the request inputs feed this, so m_data_ok never reaches m_req or
    // addr_ok combinationally (a pop frees a slot only on the next cycle).
    assign w_full      = (r_pending == PW'(OUTSTANDING));
    assign w_empty     = (r_pending == '0);
    assign w_instPrio  = (r_starveCnt == SW'(STARVE_MAX)) && i_inst_req;
    assign w_grantInst = !w_full && (w_instPrio || (i_inst_req && !i_data_req));
    assign w_grantData = !w_full && i_data_req && !w_instPrio;

    // Request mux toward memory. With no grant the inst fields pass through;
    // m_req is low then, so their values do not matter.
    assign o_m_req   = w_grantInst || w_grantData;
    assign o_m_wr    = w_grantData ? i_data_wr    : i_inst_wr;
    assign o_m_size  = w_grantData ? i_data_size  : i_inst_size;
    assign o_m_addr  = w_grantData ? i_data_addr  : i_inst_addr;
    assign o_m_wdata = w_grantData ? i_data_wdata : i_inst_wdata;

    assign o_inst_addr_ok = i_m_addr_ok && w_grantInst;
    assign o_data_addr_ok = i_m_addr_ok && w_grantData;

    // A response with nothing outstanding is a stray (e.g. left over from
    // before a reset) and is ignored entirely.
    assign w_push   = o_m_req && i_m_addr_ok;
    assign w_pop    = i_m_data_ok && !w_empty;
    assign w_headId = r_idFifo[r_head];

    assign o_inst_data_ok = w_pop && !w_headId;
    assign o_data_data_ok = w_pop && w_headId;
    assign o_inst_rdata   = i_m_rdata;
    assign o_data_rdata   = i_m_rdata;
    assign o_pending      = r_pending;

    // Ordering FIFO: source ID (0=inst, 1=data) pushed on each accepted
    // address phase, popped on each routed response. Push and pop together
    // leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_idFifo  <= '0;
        end else begin
            if (w_push) begin
                r_idFifo[r_tail] <= w_grantData;
                r_tail           <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Starvation counter: counts data handshakes that happen while a fetch
    // is waiting. Any fetch handshake, or the fetch request dropping, means
    // nobody is starving any more.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starveCnt <= '0;
        end else if (o_inst_addr_ok || !i_inst_req) begin
            r_starveCnt <= '0;
        end else if (o_data_addr_ok && (r_starveCnt != SW'(STARVE_MAX))) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Self-checking bench for sram_bus_arbiter. A reference model (a queue of
// source IDs plus a starvation count) predicts every output each cycle.
// Directed sequences cover fetch, simultaneous requests, backpressure,
// starvation and stray responses after reset; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int OUT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instReq, instWr, dataReq, dataWr;
    logic [1:0]  instSize, dataSize;
    logic [31:0] instAddr, instWdata, dataAddr, dataWdata;
    logic        instAddrOk, instDataOk, dataAddrOk, dataDataOk;
    logic [31:0] instRdata, dataRdata;
    logic        mReq, mWr, mAddrOk, mDataOk;
    logic [1:0]  mSize;
    logic [31:0] mAddr, mWdata, mRdata;
    logic [1:0]  pending;

    // Staging values, copied onto the DUT inputs at the next falling edge.
    logic        nRst, nInstReq, nInstWr, nDataReq, nDataWr, nMAddrOk, nMDataOk;
    logic [1:0]  nInstSize, nDataSize;
    logic [31:0] nInstAddr, nInstWdata, nDataAddr, nDataWdata, nMRdata;

    // Reference model state.
    bit q[$];
    int starve;
    bit checkEnable;
    bit lastInstGrant, lastDataGrant;

    int errCount   = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_req(instReq), .i_inst_wr(instWr), .i_inst_size(instSize),
        .i_inst_addr(instAddr), .i_inst_wdata(instWdata),
        .o_inst_addr_ok(instAddrOk), .o_inst_data_ok(instDataOk), .o_inst_rdata(instRdata),
        .i_data_req(dataReq), .i_data_wr(dataWr), .i_data_size(dataSize),
        .i_data_addr(dataAddr), .i_data_wdata(dataWdata),
        .o_data_addr_ok(dataAddrOk), .o_data_data_ok(dataDataOk), .o_data_rdata(dataRdata),
        .o_m_req(mReq), .o_m_wr(mWr), .o_m_size(mSize), .o_m_addr(mAddr), .o_m_wdata(mWdata),
        .i_m_addr_ok(mAddrOk), .i_m_data_ok(mDataOk), .i_m_rdata(mRdata),
        .o_pending(pending)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Clear the staging values to an idle cycle with random payload fields.
    task automatic idleStaging();
        nRst = 0; nInstReq = 0; nInstWr = 0; nDataReq = 0; nDataWr = 0;
        nMAddrOk = 0; nMDataOk = 0;
        nInstSize = 2'd2; nDataSize = 2'($urandom_range(0, 2));
        nInstAddr = $urandom; nInstWdata = $urandom;
        nDataAddr = $urandom; nDataWdata = $urandom; nMRdata = $urandom;
    endtask

    // One clock cycle: drive staged inputs at the falling edge, compare all
    // outputs against the model, then advance the model past the rising edge.
    task automatic applyStimulus();
        bit full, gInst, gData, expReq, headValid;
        @(negedge clk);
        rst = nRst; instReq = nInstReq; instWr = nInstWr; instSize = nInstSize;
        instAddr = nInstAddr; instWdata = nInstWdata;
        dataReq = nDataReq; dataWr = nDataWr; dataSize = nDataSize;
        dataAddr = nDataAddr; dataWdata = nDataWdata;
        mAddrOk = nMAddrOk; mDataOk = nMDataOk; mRdata = nMRdata;
        #1;
        full      = (q.size() == OUT);
        gInst     = !full && instReq && ((starve == SMAX) || !dataReq);
        gData     = !full && dataReq && !gInst;
        expReq    = gInst || gData;
        headValid = (q.size() > 0);
        lastInstGrant = instAddrOk;
        lastDataGrant = dataAddrOk;
        if (checkEnable) begin
            checkOutput("m_req", 32'(mReq), 32'(expReq));
            checkOutput("inst_addr_ok", 32'(instAddrOk), 32'(gInst && mAddrOk));
            checkOutput("data_addr_ok", 32'(dataAddrOk), 32'(gData && mAddrOk));
            checkOutput("inst_data_ok", 32'(instDataOk),
                        32'(mDataOk && headValid && (q[0] == 1'b0)));
            checkOutput("data_data_ok", 32'(dataDataOk),
                        32'(mDataOk && headValid && (q[0] == 1'b1)));
            checkOutput("pending", 32'(pending), 32'(q.size()));
            checkOutput("inst_rdata", instRdata, mRdata);
            checkOutput("data_rdata", dataRdata, mRdata);
            if (expReq) begin
                checkOutput("m_addr", mAddr, gData ? dataAddr : instAddr);
                checkOutput("m_wdata", mWdata, gData ? dataWdata : instWdata);
                checkOutput("m_wr", 32'(mWr), 32'(gData ? dataWr : instWr));
                checkOutput("m_size", 32'(mSize), 32'(gData ? dataSize : instSize));
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            starve = 0;
        end else begin
            if (mDataOk && headValid) void'(q.pop_front());
            if (expReq && mAddrOk) q.push_back(gData);
            if ((gInst && mAddrOk) || !instReq) starve = 0;
            else if (gData && mAddrOk && starve < SMAX) starve++;
        end
    endtask

    task automatic resetCycle();
        idleStaging();
        nRst = 1;
        applyStimulus();
        idleStaging();
    endtask

    int dataRun;
    bit grants[8];

    initial begin
        q.delete();
        starve = 0;
        checkEnable = 0;
        resetCycle();
        resetCycle();
        checkEnable = 1;

        // Single fetch: address accepted in cycle 0, response in cycle 2.
        idleStaging();
        nInstReq = 1; nInstAddr = 32'hBFC0_0000; nMAddrOk = 1;
        applyStimulus();
        checkOutput("fetch_addr_ok", 32'(lastInstGrant), 32'd1);
        idleStaging();
        applyStimulus();
        checkOutput("fetch_pending1", 32'(pending), 32'd1);
        idleStaging();
        nMDataOk = 1; nMRdata = 32'h3C1A_0001;
        applyStimulus();
        idleStaging();
        applyStimulus();
        checkOutput("fetch_pending0", 32'(pending), 32'd0);

        // Simultaneous requests: data store first, fetch next, responses in order.
        idleStaging();
        nInstReq = 1; nDataReq = 1; nDataWr = 1; nDataAddr = 32'h8000_0010; nMAddrOk = 1;
        applyStimulus();
        checkOutput("simul_data_first", 32'(lastDataGrant), 32'd1);
        nDataReq = 0;
        applyStimulus();
        checkOutput("simul_inst_next", 32'(lastInstGrant), 32'd1);
        idleStaging();
        nMDataOk = 1;
        applyStimulus();
        applyStimulus();
        idleStaging();
        applyStimulus();

        // Full backpressure: two accepted fetches, then stall until a response.
        nInstReq = 1; nMAddrOk = 1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("full_no_grant", 32'(lastInstGrant), 32'd0);
        nMDataOk = 1;
        applyStimulus();
        nMDataOk = 0;
        applyStimulus();
        checkOutput("full_regrant", 32'(lastInstGrant), 32'd1);

        // Starvation: both requesters held, responses returned each cycle.
        resetCycle();
        nInstReq = 1; nDataReq = 1; nMAddrOk = 1; nMDataOk = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            grants[i] = lastInstGrant;
        end
        dataRun = 0;
        while (dataRun < 8 && !grants[dataRun]) dataRun++;
        checkOutput("starve_data_run", 32'(dataRun), 32'd4);
        checkOutput("starve_data_resume", 32'(grants[5]), 32'd0);

        // Stray responses after a mid-operation reset, then a normal fetch.
        resetCycle();
        nInstReq = 1; nMAddrOk = 1;
        applyStimulus();
        applyStimulus();
        resetCycle();
        nMDataOk = 1;
        applyStimulus();
        checkOutput("stray_inst_data_ok", 32'(instDataOk), 32'd0);
        applyStimulus();
        checkOutput("stray_pending", 32'(pending), 32'd0);
        idleStaging();
        nInstReq = 1; nMAddrOk = 1;
        applyStimulus();
        idleStaging();
        nMDataOk = 1;
        applyStimulus();

        // Randomized traffic with occasional resets and stray responses.
        for (int i = 0; i < 1500; i++) begin
            idleStaging();
            nRst     = ($urandom_range(0, 63) == 0);
            nInstReq = $urandom_range(0, 1);
            nInstWr  = ($urandom_range(0, 15) == 0);
            nDataReq = $urandom_range(0, 1);
            nDataWr  = $urandom_range(0, 1);
            nMAddrOk = ($urandom_range(0, 3) != 0);
            nMDataOk = $urandom_range(0, 1);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline's inst_*/data_* handshake signals (consumed by the stall/refresh control unit) and the single cache/AXI-bridge port.
- Arbitrates address phases with data priority plus an anti-starvation limit for fetch.
- Tracks outstanding transactions in order and routes each data_ok/rdata back to its originator.

Parameters:
OUTSTANDING, 2, max in-flight transactions on m_* port; power of two, >=1
STARVE_MAX, 4, consecutive data grants tolerated while inst_req waits before inst gets priority; >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  fetch request
inst_wr  in  1  fetch write flag (normally 0)
inst_size  in  2  fetch size
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req  in  1  load/store request
data_wr  in  1  1=store
data_size  in  2  access size
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data response valid (store ack or load data)
data_rdata  out  32  load data
m_req  out  1  request to memory port
m_wr  out  1  selected write flag
m_size  out  2  selected size
m_addr  out  32  selected address
m_wdata  out  32  selected write data
m_addr_ok  in  1  memory accepted address
m_data_ok  in  1  memory response valid
m_rdata  in  32  memory read data
pending  out  $clog2(OUTSTANDING)+1  in-flight transaction count

Behaviour:
- Handshake: address phase completes on a cycle with req && addr_ok. The response (data_ok) arrives no earlier than the cycle after its address handshake. Responses on m_* return strictly in address-handshake order.
- Grant (combinational, each cycle):
  - If pending==OUTSTANDING, nothing is granted: m_req=0, both addr_ok=0. A pop in the same cycle does not free a slot until the next cycle.
  - Otherwise, if starve_cnt==STARVE_MAX and inst_req: inst granted.
  - Otherwise, if data_req: data granted.
  - Otherwise, if inst_req: inst granted.
- m_req = granted requester's req. m_wr/m_size/m_addr/m_wdata mux from the granted requester. With no grant they mux inst_* fields, don't-care.
- inst_addr_ok = m_addr_ok && inst granted && inst_req. data_addr_ok likewise for data. Never both high.
- Ordering FIFO: OUTSTANDING entries, 1-bit source ID (0=inst, 1=data).
  - Push the granted ID on m_req&&m_addr_ok.
  - Pop on m_data_ok.
  - Push and pop in the same cycle leaves pending unchanged; head/tail pointers wrap modulo OUTSTANDING.
- Response routing is combinational from the FIFO head:
  - inst_data_ok = m_data_ok && pending!=0 && head==0.
  - data_data_ok = m_data_ok && pending!=0 && head==1.
  - inst_rdata = data_rdata = m_rdata.
- m_data_ok while pending==0: dropped. No data_ok is raised, FIFO is unchanged, pending stays 0.
- starve_cnt (width covers STARVE_MAX), updated on each clock:
  - Cleared when an inst address handshake completes, or when inst_req=0.
  - Otherwise incremented (saturating at STARVE_MAX) when a data address handshake completes while inst_req=1.
- Reset (rst=1 at clk edge): pending=0, pointers=0, starve_cnt=0.
  - The next cycle all outputs are idle except the combinational pass-throughs of live requests: m_req follows the grant rule, inst_data_ok=data_data_ok=0 unless m_data_ok with a non-empty FIFO (impossible immediately after reset).
  - Reset mid-operation discards all in-flight IDs. Late m_data_ok responses are dropped by the empty rule.
- No combinational path from m_data_ok to m_req or addr_ok.

Test Plan:
- Single fetch: inst_req=1, addr 0xBFC00000, m_addr_ok=1 in cycle 0, m_data_ok=1 with rdata 0x3C1A0001 in cycle 2 -> inst_addr_ok=1 in cycle 0; pending 1 over cycles 1-2; inst_data_ok=1 with inst_rdata=0x3C1A0001 in cycle 2; data_data_ok=0 throughout.
- Simultaneous requests: inst_req=data_req=1, data_wr=1, data_addr 0x80000010, m_addr_ok=1 -> data granted first (m_wr=1, m_addr=0x80000010), inst granted the next cycle; two m_data_ok pulses -> data_data_ok then inst_data_ok, in order.
- Full backpressure, OUTSTANDING=2: two accepted requests, no m_data_ok -> m_req=0 and both addr_ok=0 while pending=2. After one m_data_ok, m_req rises the following cycle.
- Starvation, STARVE_MAX=4: data_req and inst_req held high, m_addr_ok=1, responses returned -> exactly 4 data grants, then 1 inst grant, then data resumes; starve_cnt=0 after the inst grant.
- Stray response and reset: rst asserted with pending=2, then m_data_ok pulses twice -> inst/data_data_ok stay 0; pending=0 after reset; a new fetch afterwards completes normally.
